uart_rx_frame_decoder: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_frame_decoder_if.sv | 27 ++
 rtl/uart_rx_frame_decoder_parity_calc.sv | 15 +
 rtl/uart_rx_frame_decoder.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_frame_decoder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame decoder: state encoding,
// parity-type constants and the supported oversampling ratios.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

endpackage

// File: rtl/uart_rx_frame_decoder_if.sv
// Sampler-side / system-side signal bundle of the frame decoder.
// master = the sampler/testbench side, slave = the decoder.
interface uart_rx_frame_decoder_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [5:0]            PRESCALE;
    logic [5:0]            edge_cnt;
    logic                  frame_active;
    logic                  sampled_bit;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  strt_glitch;

    modport master (
        output PRESCALE, edge_cnt, frame_active, sampled_bit, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err, strt_glitch
    );

    modport slave (
        input  PRESCALE, edge_cnt, frame_active, sampled_bit, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err, strt_glitch
    );
endinterface

// File: rtl/uart_rx_frame_decoder_parity_calc.sv
// Expected parity bit for a received data word (even: XOR of data, odd: its
// inverse). Only built when UART_RX_PARITY_EN is defined.
`ifdef UART_RX_PARITY_EN
module rx_parity_calc
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  par_o
);
    assign par_o = (par_typ_i == PAR_ODD) ? ~(^data_i) : ^data_i;
endmodule
`endif

// File: rtl/uart_rx_frame_decoder.sv
// UART receive frame decoder: tracks start/data/parity/stop per bit-end strobe
// and delivers the byte with error flags. Parity support: UART_RX_PARITY_EN.
module uart_rx_frame_decoder
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic                    CLK,
    input logic                    RST,
    uart_rx_frame_decoder_if.slave bus
);
    localparam int unsigned      IDX_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic                  glitch_q, glitch_d;
    logic                  stp_err_q, stp_err_d;
    logic                  par_err_q;
    logic [5:0]            last_edge;
    logic                  bit_end;

    // 6-bit subtraction wraps modulo 64 by construction
    assign last_edge = bus.PRESCALE - 6'd1;
    assign bit_end   = bus.frame_active && (bus.edge_cnt == last_edge);

`ifdef UART_RX_PARITY_EN
    logic par_err_d;
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
    logic exp_par;

    rx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity_calc (
        .data_i    (shift_q),
        .par_typ_i (par_typ_q),
        .par_o     (exp_par)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            par_err_q <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
        end else begin
            par_err_q <= par_err_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
        end
    end
`else
    logic unused_par_cfg;
    assign unused_par_cfg = bus.PAR_EN ^ bus.PAR_TYP;
    assign par_err_q      = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            pdata_q   <= '0;
            valid_q   <= 1'b0;
            glitch_q  <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            pdata_q   <= pdata_d;
            valid_q   <= valid_d;
            glitch_q  <= glitch_d;
            stp_err_q <= stp_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        pdata_d   = pdata_q;
        valid_d   = 1'b0;
        glitch_d  = 1'b0;
        stp_err_d = stp_err_q;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
`endif
        // Abort has priority over a coincident bit_end; flags are left as-is
        if (state_q != ST_IDLE && !bus.frame_active) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.frame_active) begin
                        state_d   = ST_START;
                        shift_d   = '0;
                        idx_d     = '0;
                        stp_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                        par_err_d = 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        if (!bus.sampled_bit) begin
                            state_d = ST_DATA;
`ifdef UART_RX_PARITY_EN
                            par_en_d  = bus.PAR_EN;
                            par_typ_d = bus.PAR_TYP;
`endif
                        end else begin
                            glitch_d = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_d = {bus.sampled_bit, shift_q[DATA_WIDTH-1:1]};
                        idx_d   = idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        if (exp_par != bus.sampled_bit) begin
                            par_err_d = 1'b1;
                        end
                        state_d = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        stp_err_d = ~bus.sampled_bit;
                        if (bus.sampled_bit && !par_err_q) begin
                            pdata_d = shift_q;
                            valid_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.P_DATA      = pdata_q;
    assign bus.data_valid  = valid_q;
    assign bus.par_err     = par_err_q;
    assign bus.stp_err     = stp_err_q;
    assign bus.strt_glitch = glitch_q;

endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// Self-checking bench for uart_rx_frame_decoder: table of frames driven bit by
// bit with a scoreboard of expected per-frame outcomes.
module tb_uart_rx_frame_decoder;
    import uart_rx_pkg::*;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    uart_rx_frame_decoder_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_frame_decoder #(.DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [5:0] ps;
        bit         par_en;
        bit         par_typ;
        logic [7:0] data;
        bit         par_bit;
        bit         start_bit;
        bit         stop_bit;
        int         abort_at;
        int         rst_at;
        bit         b2b;
        bit         exp_valid;
        bit         exp_glitch;
        bit         exp_par;
        bit         exp_stp;
        logic [7:0] exp_pdata;
    } vec_t;

    typedef struct {
        bit         valid;
        bit         glitch;
        bit         par;
        bit         stp;
        logic [7:0] pdata;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[13];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned last_cyc = 0;
    int unsigned valid_hi = 0;
    int unsigned glitch_hi = 0;
    int unsigned valid_cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (bus.data_valid) begin
            valid_hi  = valid_hi + 1;
            valid_cyc = cyc;
        end
        if (bus.strt_glitch) glitch_hi = glitch_hi + 1;
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        last_cyc = cyc;
    endtask

    function automatic vec_t mk(input logic [5:0] ps, input bit pe, input bit pt,
                                input logic [7:0] d, input bit pb, input bit sb_,
                                input bit stp, input int ab, input int ra, input bit b2b,
                                input bit ev, input bit eg, input bit ep, input bit es,
                                input logic [7:0] epd);
        vec_t v;
        v.ps = ps; v.par_en = pe; v.par_typ = pt; v.data = d; v.par_bit = pb;
        v.start_bit = sb_; v.stop_bit = stp; v.abort_at = ab; v.rst_at = ra; v.b2b = b2b;
        v.exp_valid = ev; v.exp_glitch = eg; v.exp_par = ep; v.exp_stp = es;
        v.exp_pdata = epd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        bit          bits[12];
        int          nb = 0;
        int          half;
        bit          dropped = 1'b0;
        int unsigned v0, g0, stop_cyc;
        exp_t        e;
        string       tag;

        tag = $sformatf("v%0d", idx);
        bits[nb++] = v.start_bit;
        for (int i = 0; i < 8; i++) bits[nb++] = v.data[i];
        if (v.par_en && PAR_BUILD) bits[nb++] = v.par_bit;
        bits[nb++] = v.stop_bit;
        half = int'(v.ps) / 2 + 2;

        sb.push_back('{v.exp_valid, v.exp_glitch, v.exp_par, v.exp_stp, v.exp_pdata});
        v0 = valid_hi;
        g0 = glitch_hi;
        bus.PRESCALE = v.ps;
        bus.PAR_EN   = v.par_en;
        bus.PAR_TYP  = v.par_typ;
        bus.frame_active = 1'b1;

        for (int b = 0; b < nb; b++) begin
            if (dropped) break;
            for (int ed = 0; ed < int'(v.ps); ed++) begin
                if (b == v.abort_at && ed == 0) begin
                    bus.frame_active = 1'b0;
                    dropped = 1'b1;
                    break;
                end
                bus.edge_cnt = 6'(ed);
                if (ed == half) bus.sampled_bit = bits[b];
                if (b == v.rst_at && ed == 3) begin
                    RST = 1'b0;
                    bus.frame_active = 1'b0;
                    tick();
                    @(negedge CLK);
                    #1;
                    chk({tag, "_rst_pdata"}, bus.P_DATA, 0);
                    chk({tag, "_rst_valid"}, bus.data_valid, 0);
                    chk({tag, "_rst_par"}, bus.par_err, 0);
                    chk({tag, "_rst_stp"}, bus.stp_err, 0);
                    chk({tag, "_rst_glitch"}, bus.strt_glitch, 0);
                    RST = 1'b1;
                    dropped = 1'b1;
                    break;
                end
                tick();
            end
        end
        stop_cyc = last_cyc;
        if (dropped) begin
            tick();
            tick();
        end
        @(negedge CLK);
        #1;

        e = sb.pop_front();
        chk({tag, "_valid_pulses"}, valid_hi - v0, 32'(e.valid));
        chk({tag, "_glitch_pulses"}, glitch_hi - g0, 32'(e.glitch));
        chk({tag, "_pdata"}, bus.P_DATA, e.pdata);
        chk({tag, "_par_err"}, bus.par_err, e.par);
        chk({tag, "_stp_err"}, bus.stp_err, e.stp);
        if (e.valid) chk({tag, "_valid_latency"}, valid_cyc, stop_cyc);

        if (!v.b2b) begin
            bus.frame_active = 1'b0;
            bus.edge_cnt = '0;
            repeat (3) tick();
        end
    endtask

    initial begin
        // ps  pe pt data   pb st sp abort rst b2b  valid glitch par stp pdata
        vecs[0]  = mk(PRESCALE_8,  0, 0, 8'hA5, 0, 0, 1, -1, -1, 0, 1, 0, 0, 0, 8'hA5);
`ifdef UART_RX_PARITY_EN
        vecs[1]  = mk(PRESCALE_16, 1, 0, 8'h03, 1, 0, 1, -1, -1, 0, 0, 0, 1, 0, 8'hA5);
        vecs[2]  = mk(PRESCALE_32, 1, 1, 8'h07, 0, 0, 0, -1, -1, 0, 0, 0, 0, 1, 8'hA5);
        vecs[3]  = mk(PRESCALE_8,  0, 0, 8'h00, 0, 1, 1,  1, -1, 0, 0, 1, 0, 0, 8'hA5);
        vecs[4]  = mk(PRESCALE_16, 0, 0, 8'h55, 0, 0, 1,  6, -1, 0, 0, 0, 0, 0, 8'hA5);
`else
        vecs[1]  = mk(PRESCALE_16, 1, 0, 8'h03, 1, 0, 1, -1, -1, 0, 1, 0, 0, 0, 8'h03);
        vecs[2]  = mk(PRESCALE_32, 1, 1, 8'h07, 0, 0, 0, -1, -1, 0, 0, 0, 0, 1, 8'h03);
        vecs[3]  = mk(PRESCALE_8,  0, 0, 8'h00, 0, 1, 1,  1, -1, 0, 0, 1, 0, 0, 8'h03);
        vecs[4]  = mk(PRESCALE_16, 0, 0, 8'h55, 0, 0, 1,  6, -1, 0, 0, 0, 0, 0, 8'h03);
`endif
        vecs[5]  = mk(PRESCALE_16, 0, 0, 8'h3C, 0, 0, 1, -1, -1, 0, 1, 0, 0, 0, 8'h3C);
        vecs[6]  = mk(PRESCALE_8,  1, 1, 8'h5A, 1, 0, 1, -1, -1, 0, 1, 0, 0, 0, 8'h5A);
        vecs[7]  = mk(PRESCALE_32, 1, 0, 8'h80, 1, 0, 1, -1, -1, 0, 1, 0, 0, 0, 8'h80);
`ifdef UART_RX_PARITY_EN
        vecs[8]  = mk(PRESCALE_8,  1, 0, 8'hFF, 1, 0, 0, -1, -1, 0, 0, 0, 1, 1, 8'h80);
`else
        vecs[8]  = mk(PRESCALE_8,  1, 0, 8'hFF, 1, 0, 0, -1, -1, 0, 0, 0, 0, 1, 8'h80);
`endif
        vecs[9]  = mk(PRESCALE_16, 0, 0, 8'hC3, 0, 0, 1, -1, -1, 1, 1, 0, 0, 0, 8'hC3);
        vecs[10] = mk(PRESCALE_16, 1, 1, 8'h12, 1, 0, 1, -1, -1, 0, 1, 0, 0, 0, 8'h12);
        vecs[11] = mk(PRESCALE_16, 0, 0, 8'h81, 0, 0, 1, -1,  7, 0, 0, 0, 0, 0, 8'h00);
        vecs[12] = mk(PRESCALE_16, 0, 0, 8'h81, 0, 0, 1, -1, -1, 0, 1, 0, 0, 0, 8'h81);

        RST = 1'b0;
        bus.PRESCALE     = PRESCALE_8;
        bus.edge_cnt     = '0;
        bus.frame_active = 1'b0;
        bus.sampled_bit  = 1'b1;
        bus.PAR_EN       = 1'b0;
        bus.PAR_TYP      = PAR_EVEN;
        repeat (3) tick();
        @(negedge CLK);
        #1;
        chk("reset_pdata", bus.P_DATA, 0);
        chk("reset_valid", bus.data_valid, 0);
        chk("reset_par", bus.par_err, 0);
        chk("reset_stp", bus.stp_err, 0);
        chk("reset_glitch", bus.strt_glitch, 0);
        RST = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
